test_pattern_gen: RTL and testbench

//  Pixel source directly downstream of video_sig_gen. Consumes its hcount/vcount/sync/active/new-frame/frame-count

---
 rtl/test_pattern_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_test_pattern_gen.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/test_pattern_gen.sv
// test_pattern_gen: two-stage pixel source fed by video_sig_gen timing (bars, checker, gradient, box).
// Define TPG_BOX_EN to build the bouncing-box pattern; otherwise pattern 3 is flat grey in the active region.
module test_pattern_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int ACTIVE_LINES    = 720,
  parameter int CHECK_LOG2      = 5,
  parameter int BOX_SIZE        = 64,
  parameter int BOX_SPEED       = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        ad_in,
  input  logic        nf_in,
  input  logic [5:0]  fc_in,
  input  logic [1:0]  pattern_sel_in,
  output logic [7:0]  red_out,
  output logic [7:0]  green_out,
  output logic [7:0]  blue_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out
);

  localparam int BAR_W = ACTIVE_H_PIXELS / 8;
  localparam logic [10:0] BAR_1 = 11'(1 * BAR_W);
  localparam logic [10:0] BAR_2 = 11'(2 * BAR_W);
  localparam logic [10:0] BAR_3 = 11'(3 * BAR_W);
  localparam logic [10:0] BAR_4 = 11'(4 * BAR_W);
  localparam logic [10:0] BAR_5 = 11'(5 * BAR_W);
  localparam logic [10:0] BAR_6 = 11'(6 * BAR_W);
  localparam logic [10:0] BAR_7 = 11'(7 * BAR_W);

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_GRAD  = 2'd2,
    PAT_BOX   = 2'd3
  } pattern_t;

  logic [10:0] r_h1;
  logic [9:0]  r_v1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_ad1;
  logic [5:0]  r_fc1;
  pattern_t    r_pattern;

  logic [2:0]  w_bar_idx;
  logic [23:0] w_bar_rgb;
  logic [23:0] w_box_rgb;
  logic [23:0] w_rgb;

  // Stage 1: capture timing inputs; the pattern only switches on a new-frame strobe.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_h1      <= 11'd0;
      r_v1      <= 10'd0;
      r_hs1     <= 1'b0;
      r_vs1     <= 1'b0;
      r_ad1     <= 1'b0;
      r_fc1     <= 6'd0;
      r_pattern <= PAT_BARS;
    end else begin
      r_h1  <= hcount_in;
      r_v1  <= vcount_in;
      r_hs1 <= hs_in;
      r_vs1 <= vs_in;
      r_ad1 <= ad_in;
      r_fc1 <= fc_in;
      if (nf_in) begin
        r_pattern <= pattern_t'(pattern_sel_in);
      end
    end
  end

  // Bar index from a comparator ladder, avoiding a divider.
  always_comb begin
    w_bar_idx = 3'd7;
    if      (r_h1 < BAR_1) w_bar_idx = 3'd0;
    else if (r_h1 < BAR_2) w_bar_idx = 3'd1;
    else if (r_h1 < BAR_3) w_bar_idx = 3'd2;
    else if (r_h1 < BAR_4) w_bar_idx = 3'd3;
    else if (r_h1 < BAR_5) w_bar_idx = 3'd4;
    else if (r_h1 < BAR_6) w_bar_idx = 3'd5;
    else if (r_h1 < BAR_7) w_bar_idx = 3'd6;
    else                   w_bar_idx = 3'd7;
  end

  always_comb begin
    w_bar_rgb = 24'h000000;
    case (w_bar_idx)
      3'd0:    w_bar_rgb = 24'hFFFFFF;
      3'd1:    w_bar_rgb = 24'hFFFF00;
      3'd2:    w_bar_rgb = 24'h00FFFF;
      3'd3:    w_bar_rgb = 24'h00FF00;
      3'd4:    w_bar_rgb = 24'hFF00FF;
      3'd5:    w_bar_rgb = 24'hFF0000;
      3'd6:    w_bar_rgb = 24'h0000FF;
      3'd7:    w_bar_rgb = 24'h000000;
      default: w_bar_rgb = 24'h000000;
    endcase
  end

`ifdef TPG_BOX_EN
  localparam logic signed [11:0] X_MAX  = 12'(ACTIVE_H_PIXELS - BOX_SIZE);
  localparam logic signed [10:0] Y_MAX  = 11'(ACTIVE_LINES - BOX_SIZE);
  localparam logic signed [11:0] X_STEP = 12'(BOX_SPEED);
  localparam logic signed [10:0] Y_STEP = 11'(BOX_SPEED);

  logic [10:0]        r_box_x;
  logic [9:0]         r_box_y;
  logic               r_dir_x;
  logic               r_dir_y;
  logic signed [11:0] w_x_sum;
  logic signed [10:0] w_y_sum;
  logic [10:0]        w_x_next;
  logic [9:0]         w_y_next;
  logic               w_dir_x_next;
  logic               w_dir_y_next;
  logic [11:0]        w_x_end;
  logic [10:0]        w_y_end;
  logic               w_in_box;

  // Next box position: step one bit wider and signed, clamp at either wall and reverse.
  always_comb begin
    w_x_sum      = r_dir_x ? ($signed({1'b0, r_box_x}) + X_STEP) : ($signed({1'b0, r_box_x}) - X_STEP);
    w_y_sum      = r_dir_y ? ($signed({1'b0, r_box_y}) + Y_STEP) : ($signed({1'b0, r_box_y}) - Y_STEP);
    w_x_next     = r_box_x;
    w_dir_x_next = r_dir_x;
    w_y_next     = r_box_y;
    w_dir_y_next = r_dir_y;
    if (w_x_sum < 12'sd0) begin
      w_x_next     = 11'd0;
      w_dir_x_next = ~r_dir_x;
    end else if (w_x_sum > X_MAX) begin
      w_x_next     = X_MAX[10:0];
      w_dir_x_next = ~r_dir_x;
    end else begin
      w_x_next     = w_x_sum[10:0];
      w_dir_x_next = r_dir_x;
    end
    if (w_y_sum < 11'sd0) begin
      w_y_next     = 10'd0;
      w_dir_y_next = ~r_dir_y;
    end else if (w_y_sum > Y_MAX) begin
      w_y_next     = Y_MAX[9:0];
      w_dir_y_next = ~r_dir_y;
    end else begin
      w_y_next     = w_y_sum[9:0];
      w_dir_y_next = r_dir_y;
    end
  end

  // Box moves once per frame regardless of which pattern is on screen.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      r_box_x <= 11'd0;
      r_box_y <= 10'd0;
      r_dir_x <= 1'b1;
      r_dir_y <= 1'b1;
    end else if (nf_in) begin
      r_box_x <= w_x_next;
      r_box_y <= w_y_next;
      r_dir_x <= w_dir_x_next;
      r_dir_y <= w_dir_y_next;
    end
  end

  always_comb begin
    w_x_end   = {1'b0, r_box_x} + 12'(BOX_SIZE);
    w_y_end   = {1'b0, r_box_y} + 11'(BOX_SIZE);
    w_in_box  = (r_h1 >= r_box_x) && ({1'b0, r_h1} < w_x_end) &&
                (r_v1 >= r_box_y) && ({1'b0, r_v1} < w_y_end);
    w_box_rgb = w_in_box ? 24'hFFFFFF : 24'h0000FF;
  end
`else
  logic w_unused;
  assign w_unused  = ^r_v1[9:8];
  assign w_box_rgb = 24'h808080;
`endif

  // Pattern mux; blanking wins over every pattern.
  always_comb begin
    w_rgb = 24'h000000;
    if (!r_ad1) begin
      w_rgb = 24'h000000;
    end else begin
      case (r_pattern)
        PAT_BARS:  w_rgb = w_bar_rgb;
        PAT_CHECK: w_rgb = (r_h1[CHECK_LOG2] ^ r_v1[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
        PAT_GRAD:  w_rgb = {r_h1[7:0], r_v1[7:0], r_fc1, 2'b00};
        PAT_BOX:   w_rgb = w_box_rgb;
        default:   w_rgb = 24'h000000;
      endcase
    end
  end

  // Stage 2: registered outputs, sync flags kept aligned with the pixel.
  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      red_out   <= 8'd0;
      green_out <= 8'd0;
      blue_out  <= 8'd0;
      hs_out    <= 1'b0;
      vs_out    <= 1'b0;
      ad_out    <= 1'b0;
    end else begin
      red_out   <= w_rgb[23:16];
      green_out <= w_rgb[15:8];
      blue_out  <= w_rgb[7:0];
      hs_out    <= r_hs1;
      vs_out    <= r_vs1;
      ad_out    <= r_ad1;
    end
  end

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: directed scenarios plus randomized timing checked against a frame-level model.
module tb_test_pattern_gen;

  localparam int H_ACT = 1280;
  localparam int V_ACT = 720;
  localparam int BOX   = 64;
  localparam int SPD   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h;
  logic [9:0]  v;
  logic        hs, vs, ad, nf;
  logic [5:0]  fc;
  logic [1:0]  sel;
  logic [7:0]  r_o, g_o, b_o;
  logic        hs_o, vs_o, ad_o;

  always #5 clk = ~clk;

  test_pattern_gen dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .hcount_in      (h),
    .vcount_in      (v),
    .hs_in          (hs),
    .vs_in          (vs),
    .ad_in          (ad),
    .nf_in          (nf),
    .fc_in          (fc),
    .pattern_sel_in (sel),
    .red_out        (r_o),
    .green_out      (g_o),
    .blue_out       (b_o),
    .hs_out         (hs_o),
    .vs_out         (vs_o),
    .ad_out         (ad_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: latched pattern, box position/direction, two-deep output pipe.
  int          m_pat;
  int          bx, by, dx, dy;
  logic [26:0] m_pipe, m_out;
  logic [23:0] bar_tab [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [23:0] ref_rgb(input int hh, input int vv, input bit a, input int f, input int pat);
    int idx;
    if (!a) return 24'h000000;
    case (pat)
      0: begin
        idx = hh / (H_ACT / 8);
        if (idx > 7) idx = 7;
        return bar_tab[idx];
      end
      1: return ((((hh >> 5) ^ (vv >> 5)) & 1) == 1) ? 24'hFFFFFF : 24'h000000;
      2: return {8'(hh % 256), 8'(vv % 256), 8'((f * 4) % 256)};
      default: begin
`ifdef TPG_BOX_EN
        if (hh >= bx && hh < bx + BOX && vv >= by && vv < by + BOX) return 24'hFFFFFF;
        return 24'h0000FF;
`else
        return 24'h808080;
`endif
      end
    endcase
  endfunction

  task automatic box_step(inout int p, inout int d, input int mx);
    p = p + d * SPD;
    if (p < 0) begin p = 0; d = -d; end
    else if (p > mx) begin p = mx; d = -d; end
  endtask

  // One clock: advance the model at the edge, then compare outputs 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      m_pat = 0; bx = 0; by = 0; dx = 1; dy = 1;
      m_out = 27'd0; m_pipe = 27'd0;
    end else begin
      if (nf) begin
        m_pat = int'(sel);
        box_step(bx, dx, H_ACT - BOX);
        box_step(by, dy, V_ACT - BOX);
      end
      m_out  = m_pipe;
      m_pipe = {hs, vs, ad, ref_rgb(int'(h), int'(v), ad, int'(fc), m_pat)};
    end
    #1;
    check_val("rgb_model", {8'h00, r_o, g_o, b_o}, {8'h00, m_out[23:0]});
    check_val("sync_model", {29'd0, hs_o, vs_o, ad_o}, {29'd0, m_out[26:24]});
  endtask

  task automatic set_px(input int hh, input int vv, input bit a, input bit n, input int s, input int f);
    h = 11'(hh); v = 10'(vv); ad = a; nf = n; sel = 2'(s); fc = 6'(f); hs = 1'b0; vs = 1'b0;
  endtask

  task automatic lit(input string tag, input int hh, input int vv, input int f, input logic [23:0] exp);
    set_px(hh, vv, 1'b1, 1'b0, int'(sel), f);
    cycle();
    ad = 1'b0;
    cycle();
    check_val(tag, {8'h00, r_o, g_o, b_o}, {8'h00, exp});
  endtask

  task automatic new_frame(input int s);
    set_px(0, 0, 1'b0, 1'b1, s, 0);
    cycle();
    nf = 1'b0;
  endtask

  initial begin
    int hh, vv;
    bar_tab[0] = 24'hFFFFFF; bar_tab[1] = 24'hFFFF00; bar_tab[2] = 24'h00FFFF; bar_tab[3] = 24'h00FF00;
    bar_tab[4] = 24'hFF00FF; bar_tab[5] = 24'hFF0000; bar_tab[6] = 24'h0000FF; bar_tab[7] = 24'h000000;
    m_pat = 0; bx = 0; by = 0; dx = 1; dy = 1; m_pipe = 27'd0; m_out = 27'd0;
    rst = 1'b1;
    set_px(0, 0, 1'b0, 1'b0, 0, 0);
    repeat (3) cycle();
    check_val("reset_rgb", {8'h00, r_o, g_o, b_o}, 32'h0);
    check_val("reset_sync", {29'd0, hs_o, vs_o, ad_o}, 32'h0);
    rst = 1'b0;

    // sync pulse appears exactly two edges later
    hs = 1'b1; vs = 1'b1; ad = 1'b0;
    cycle();
    hs = 1'b0; vs = 1'b0;
    cycle();
    check_val("pulse_hi", {30'd0, hs_o, vs_o}, 32'd3);
    check_val("pulse_rgb0", {8'h00, r_o, g_o, b_o}, 32'h0);
    cycle();
    check_val("pulse_lo", {30'd0, hs_o, vs_o}, 32'd0);

    new_frame(0);
    lit("bar_h0",    0,    0, 0, 24'hFFFFFF);
    lit("bar_h159",  159,  0, 0, 24'hFFFFFF);
    lit("bar_h160",  160,  0, 0, 24'hFFFF00);
    lit("bar_h1279", 1279, 0, 0, 24'h000000);

    sel = 2'd1;
    lit("bars_persist", 200, 0, 0, 24'hFFFF00);
    new_frame(1);
    lit("chk_32_0",  32, 0,  0, 24'hFFFFFF);
    lit("chk_32_32", 32, 32, 0, 24'h000000);

    new_frame(2);
    lit("grad", 300, 10, 5, 24'h2C0A14);
    set_px(300, 10, 1'b0, 1'b0, 2, 5);
    cycle(); cycle();
    check_val("grad_blank", {8'h00, r_o, g_o, b_o}, 32'h0);

    // reset mid-frame clears outputs, then bars until the next new-frame
    set_px(300, 10, 1'b1, 1'b0, 2, 5);
    cycle();
    rst = 1'b1;
    cycle();
    check_val("rst_mid", {8'h00, r_o, g_o, b_o}, 32'h0);
    rst = 1'b0;
    lit("post_rst_bars", 300, 10, 5, 24'hFFFF00);

`ifdef TPG_BOX_EN
    rst = 1'b1; cycle(); rst = 1'b0;
    repeat (305) new_frame(3);
    lit("box_tl",    1216, 96,  0, 24'hFFFFFF);
    lit("box_left",  1215, 96,  0, 24'h0000FF);
    lit("box_br",    1279, 159, 0, 24'h0000FF + 24'hFFFF00);
    lit("box_below", 1279, 160, 0, 24'h0000FF);
    new_frame(3);
    lit("box_back",  1212, 92,  0, 24'hFFFFFF);
    lit("box_right", 1276, 92,  0, 24'h0000FF);
`else
    new_frame(3);
    lit("grey_act", 640, 360, 0, 24'h808080);
    set_px(640, 360, 1'b0, 1'b0, 3, 0);
    cycle(); cycle();
    check_val("grey_blank", {8'h00, r_o, g_o, b_o}, 32'h0);
`endif

    // randomized frames, coordinates biased towards the box edges half the time
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        hh = bx - 8 + int'($urandom_range(0, BOX + 16));
        vv = by - 8 + int'($urandom_range(0, BOX + 16));
        if (hh < 0) hh = 0;
        if (hh > H_ACT - 1) hh = H_ACT - 1;
        if (vv < 0) vv = 0;
        if (vv > V_ACT - 1) vv = V_ACT - 1;
      end else begin
        hh = int'($urandom_range(0, H_ACT - 1));
        vv = int'($urandom_range(0, V_ACT - 1));
      end
      set_px(hh, vv, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 63)));
      hs  = 1'($urandom_range(0, 1));
      vs  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 599) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
